// File: rtl/rr_mux8_sched.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux8_sched
// Purpose  : Round-robin scheduler owning the select lines of a shared
//            8:1 single-bit mux. Grants one requester at a time, holds a
//            grant for at most HOLD cycles, then rotates priority. Returns
//            the muxed data bit registered, with a valid flag.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            req[7:0] - request vector, bit i = requester i
//            d[7:0]   - data bits, bit i from requester i
//            lock     - (RR_MUX8_SCHED_LOCK_EN only) extend the current grant
//                       past the HOLD limit while its requester keeps req high
//            sel[2:0] - mux select, index of current/last granted requester
//            gnt[7:0] - one-hot grant, zero when idle
//            y        - registered mux output, d[sel] sampled at previous edge
//            y_valid  - y holds a sample taken under an active grant
//            busy     - high while in GRANT state
// Options  : define RR_MUX8_SCHED_LOCK_EN to add the lock input
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux8_sched #(
   parameter int HOLD = 4,   // max consecutive grant cycles, 1..16
   parameter int CW   = 4    // hold-counter width, 2**CW >= HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] d,
`ifdef RR_MUX8_SCHED_LOCK_EN
   input  logic       lock,
`endif
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       y,
   output logic       y_valid,
   output logic       busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [CW-1:0] c_cnt_max = CW'(HOLD - 1);

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_ptr,   w_ptr_nxt;
   logic [CW-1:0]   r_cnt,   w_cnt_nxt;
   logic [2:0]      r_sel,   w_sel_nxt;
   logic [7:0]      r_gnt,   w_gnt_nxt;
   logic            r_y,     w_y_nxt;
   logic            r_y_valid, w_y_valid_nxt;

   logic [2:0]      w_win_idle;
   logic [2:0]      w_ptr_rot;
   logic [2:0]      w_win_rot;
   logic            w_at_max;
   logic            w_lock_hold;
   logic            w_release;

   // First requesting index scanning ptr, ptr+1, ... ptr+7 (mod 8).
   // Scanning downward lets the smallest offset overwrite the result last.
   function automatic logic [2:0] f_winner(input logic [2:0] ptr,
                                           input logic [7:0] rq);
      logic [2:0] idx;
      logic [2:0] win;
      win = ptr;
      for (int k = 7; k >= 0; k--) begin
         idx = ptr + 3'(k);
         if (rq[idx]) win = idx;
      end
      return win;
   endfunction

   // On release the pointer moves past the current owner, so the owner
   // only wins again when nobody else is requesting.
   assign w_ptr_rot  = r_sel + 3'd1;
   assign w_win_idle = f_winner(r_ptr, req);
   assign w_win_rot  = f_winner(w_ptr_rot, req);
   assign w_at_max   = (r_cnt == c_cnt_max);

`ifdef RR_MUX8_SCHED_LOCK_EN
   assign w_lock_hold = lock & req[r_sel];
`else
   assign w_lock_hold = 1'b0;
`endif

   assign w_release = ~req[r_sel] | (w_at_max & ~w_lock_hold);

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      w_sel_nxt     = r_sel;
      w_gnt_nxt     = r_gnt;
      w_y_nxt       = r_y;
      w_y_valid_nxt = r_y_valid;
      case (r_state)
         ST_IDLE: begin
            w_y_valid_nxt = 1'b0;
            if (|req) begin
               w_state_nxt = ST_GRANT;
               w_sel_nxt   = w_win_idle;
               w_gnt_nxt   = 8'b1 << w_win_idle;
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            w_y_nxt       = d[r_sel];
            w_y_valid_nxt = 1'b1;
            if (w_release) begin
               w_ptr_nxt = w_ptr_rot;
               if (|req) begin
                  w_sel_nxt = w_win_rot;
                  w_gnt_nxt = 8'b1 << w_win_rot;
                  w_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = 8'h00;
               end
            end else if (!w_at_max) begin
               // Held at the limit only under lock: counter saturates.
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 3'd0;
         r_cnt     <= '0;
         r_sel     <= 3'd0;
         r_gnt     <= 8'h00;
         r_y       <= 1'b0;
         r_y_valid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sel     <= w_sel_nxt;
         r_gnt     <= w_gnt_nxt;
         r_y       <= w_y_nxt;
         r_y_valid <= w_y_valid_nxt;
      end
   end

   assign sel     = r_sel;
   assign gnt     = r_gnt;
   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign busy    = (r_state == ST_GRANT);

endmodule
`default_nettype wire
